bk_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider: the inverse arithmetic path to the team's

---
 rtl/bk_restoring_divider.sv | 134 +++++++++++++
 tb/tb_bk_restoring_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per cycle, start/done handshake.
// Optional macro BK_DIV_ZERO_CHECK_EN adds a short-cut ZERO state for a zero divisor.
module bk_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef BK_DIV_ZERO_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ZERO} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   r_d;

    // One restoring step: shift in the next dividend bit, keep the difference only if no borrow.
    function automatic logic [2*WIDTH-1:0] trial_step(input logic [WIDTH-1:0] r,
                                                      input logic [WIDTH-1:0] q,
                                                      input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r_sh;
        logic [WIDTH:0]   diff;
        r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
        diff = {1'b0, r_sh} + {1'b1, ~d} + (WIDTH+1)'(1);
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        end
        return {r_sh, q[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        {r_d, q_d} = trial_step(r_q, q_q, d_q);
    end

`ifdef BK_DIV_ZERO_CHECK_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BK_DIV_ZERO_CHECK_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        d_q    <= divisor;
                        q_q    <= dividend;
                        r_q    <= '0;
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        busy_q <= 1'b1;
`ifdef BK_DIV_ZERO_CHECK_EN
                        dbz_q   <= 1'b0;
                        state_q <= (divisor == '0) ? S_ZERO : S_RUN;
`else
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    // Results are registered on the last step so they are valid with done.
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
`ifdef BK_DIV_ZERO_CHECK_EN
                S_ZERO: begin
                    state_q     <= S_DONE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    quotient_q  <= '1;
                    remainder_q <= q_q;
                    dbz_q       <= 1'b1;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_bk_restoring_divider.sv
// Self-checking bench for bk_restoring_divider (WIDTH=4): directed table, corner sequences,
// exhaustive sweep and randomized back-to-back operations against a plain-arithmetic model.
module tb_bk_restoring_divider;

    localparam int W = 4;

`ifdef BK_DIV_ZERO_CHECK_EN
    localparam bit ZC_EN = 1'b1;
`else
    localparam bit ZC_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int passed;
    int total;
    int cyc;

    bk_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain integer division, with the defined zero-divisor result.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int z, output int lat);
        if (b == 0) begin
            q   = (1 << W) - 1;
            r   = a;
            z   = ZC_EN ? 1 : 0;
            lat = ZC_EN ? 2 : W + 1;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = 0;
            lat = W + 1;
        end
    endfunction

    // Starts one op on the next falling edge and waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output int q, output int r, output int z);
        int c0;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        c0       = cyc;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            @(negedge clk);
        end
        q = int'(quotient);
        r = int'(remainder);
        z = int'(div_by_zero);
    endtask

    task automatic op_and_check(input string tag, input int a, input int b);
        int lat, q, r, z, eq, er, ez, elat;
        model(a, b, eq, er, ez, elat);
        run_op(W'(a), W'(b), lat, q, r, z);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dbz"}, z, ez);
        if (b != 0) begin
            check({tag, "_identity"}, q * b + r, a);
            check({tag, "_rem_lt_div"}, (r < b) ? 1 : 0, 1);
        end
    endtask

    initial begin
        int c0, lat, dones;
        passed   = 0;
        total    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        tbl[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1};
        tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0};
        tbl[2] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0};
        tbl[3] = '{a: 4'd5,  b: 4'd9, q: 4'd0,  r: 4'd5};
        tbl[4] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7};
        tbl[5] = '{a: 4'd9,  b: 4'd4, q: 4'd2,  r: 4'd1};
        tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0};

        #13;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 13/3 with cycle-by-cycle handshake observation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3; c0 = cyc;
        @(negedge clk);
        start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("hs_busy_c%0d", c), busy, 1);
            check($sformatf("hs_done_c%0d", c), done, 0);
            @(negedge clk);
        end
        check("hs_done_c5", done, 1);
        check("hs_busy_c5", busy, 0);
        check("hs_q", quotient, 4);
        check("hs_r", remainder, 1);
        check("hs_dbz", div_by_zero, 0);
        @(negedge clk);
        check("hs_done_pulse", done, 0);
        check("hs_q_held", quotient, 4);
        check("hs_r_held", remainder, 1);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            int q, r, z, elat;
            run_op(tbl[i].a, tbl[i].b, lat, q, r, z);
            elat = (ZC_EN && tbl[i].b == 0) ? 2 : W + 1;
            check($sformatf("tbl%0d_lat", i), lat, elat);
            check($sformatf("tbl%0d_q", i), q, tbl[i].q);
            check($sformatf("tbl%0d_r", i), r, tbl[i].r);
            check($sformatf("tbl%0d_dbz", i), z, (ZC_EN && tbl[i].b == 0) ? 1 : 0);
        end

        // Start pulsed mid-operation must be ignored; next start right as done falls.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = cyc - c0; break; end
            @(negedge clk);
        end
        check("ign_lat", lat, 5);
        check("ign_q", quotient, 4);
        check("ign_r", remainder, 1);
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = cyc - c0; break; end
            @(negedge clk);
        end
        check("b2b_done_cycle", lat, 11);
        check("b2b_q", quotient, 3);
        check("b2b_r", remainder, 0);

        // Reset asserted in cycle 3 of a 13/3 operation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        op_and_check("post_rst_9_4", 9, 4);

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op_and_check($sformatf("sw_%0d_%0d", a, b), a, b);
            end
        end

        // Randomized back-to-back operations.
        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = int'($urandom_range(15, 0));
            b = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(15, 0));
            op_and_check($sformatf("rnd%0d", i), a, b);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
